menu_select_ctrl: RTL and testbench

MENU_SELECT_CTRL -- requirements
Module: menu_select_ctrl

---
 rtl/menu_select_if.sv | 23 ++
 rtl/menu_select_ctrl.sv | 92 +++++++++
 tb/tb_menu_select_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/menu_select_if.sv
// menu_select_if: button/CPU-status bundle between the menu controller and its environment
// master: drives up_btn, down_btn, select_btn, cpu_halted; reads sel_index, selection_done, mode, cpu_rst_n
// slave: the controller side, the mirror of master
interface menu_select_if #(
  parameter int OPT_W = 2
);
  logic             up_btn;
  logic             down_btn;
  logic             select_btn;
  logic             cpu_halted;
  logic [OPT_W-1:0] sel_index;
  logic             selection_done;
  logic             mode;
  logic             cpu_rst_n;
  modport master (
    output up_btn, down_btn, select_btn, cpu_halted,
    input  sel_index, selection_done, mode, cpu_rst_n
  );
  modport slave (
    input  up_btn, down_btn, select_btn, cpu_halted,
    output sel_index, selection_done, mode, cpu_rst_n
  );
endinterface

// File: rtl/menu_select_ctrl.sv
// menu_select_ctrl: debounced button menu that picks a program, holds the CPU in reset while arming, then runs it
// clk: system clock; rst: asynchronous active-low reset
// bus (slave): raw buttons and cpu_halted in; sel_index, selection_done, mode, cpu_rst_n out (all registered)
module menu_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_OPTIONS     = 4,
  parameter int OPT_W           = 2
) (
  input logic          clk,
  input logic          rst,
  menu_select_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [OPT_W-1:0] LAST = OPT_W'(NUM_OPTIONS - 1);
  typedef enum logic [1:0] {SELECT, ARM, RUN, DONE} state_t;
  logic [2:0] w_raw, r_s1, r_s2, w_deb, r_deb_d, r_ev;
  logic       w_up, w_dn, w_sel;
  assign w_raw = {bus.select_btn, bus.down_btn, bus.up_btn};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb_d <= '0;
      r_ev    <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= w_deb;
      r_ev    <= w_deb & ~r_deb_d;
    end
  for (genvar b = 0; b < 3; b++) begin : g_deb
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    assign w_deb[b] = r_lvl;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_s2[b] == r_lvl) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt <= '0;
        r_lvl <= ~r_lvl;
      end else r_cnt <= r_cnt + 1'b1;
  end
  assign w_up  = r_ev[0];
  assign w_dn  = r_ev[1];
  assign w_sel = r_ev[2];
  state_t           r_state, w_nxt;
  logic [1:0]       r_arm;
  logic [OPT_W-1:0] r_idx, w_idx;
  logic             w_done, w_mode, w_crst, r_done, r_mode, r_crst;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= SELECT;
      r_arm   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt;
      r_arm   <= (r_state == ARM) ? r_arm + 2'd1 : 2'd0;
      r_idx   <= w_idx;
    end
  // select outranks cpu_halted in RUN so a simultaneous abort wins
  always_comb begin
    w_nxt = r_state == SELECT ? (w_sel ? ARM : SELECT)
          : r_state == ARM    ? (r_arm == 2'd3 ? RUN : ARM)
          : w_sel             ? SELECT
          : (r_state == RUN && bus.cpu_halted) ? DONE : r_state;
    w_idx = (r_state != SELECT || w_sel || w_up == w_dn) ? r_idx
          : w_up ? (r_idx == LAST ? '0 : r_idx + 1'b1)
          : (r_idx == '0 ? LAST : r_idx - 1'b1);
  end
  // outputs decoded from the next state so the registered copies line up with r_state
  always_comb begin
    w_mode = w_nxt == RUN;
    w_crst = w_nxt == RUN || w_nxt == DONE;
    w_done = w_nxt == ARM || w_nxt == DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_mode <= 1'b0;
      r_crst <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_mode <= w_mode;
      r_crst <= w_crst;
      r_done <= w_done;
    end
  assign bus.sel_index      = r_idx;
  assign bus.mode           = r_mode;
  assign bus.cpu_rst_n      = r_crst;
  assign bus.selection_done = r_done;
endmodule

// File: tb/tb_menu_select_ctrl.sv
// tb_menu_select_ctrl: directed and random button presses checked against a phase/index reference model
module tb_menu_select_ctrl;
  localparam int D = 4, N = 4, W = 2;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  menu_select_if #(.OPT_W(W)) bus ();
  menu_select_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_OPTIONS(N), .OPT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  int m_phase = 0;
  int m_idx = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, "_idx"}, 32'(bus.sel_index), 32'(m_idx));
    chk({tag, "_mode"}, 32'(bus.mode), 32'(m_phase == 1));
    chk({tag, "_cpurstn"}, 32'(bus.cpu_rst_n), 32'(m_phase != 0));
    chk({tag, "_done"}, 32'(bus.selection_done), 32'(m_phase == 2));
  endtask
  task automatic press(input bit u, input bit d, input bit s);
    @(negedge clk);
    bus.up_btn = u;
    bus.down_btn = d;
    bus.select_btn = s;
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.up_btn = 1'b0;
    bus.down_btn = 1'b0;
    bus.select_btn = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    if (m_phase == 0) begin
      if (s) m_phase = 1;
      else if (u && !d) m_idx = (m_idx + 1) % N;
      else if (d && !u) m_idx = (m_idx + N - 1) % N;
    end else if (s) m_phase = 0;
  endtask
  task automatic halt_pulse();
    @(negedge clk);
    bus.cpu_halted = 1'b1;
    @(negedge clk);
    bus.cpu_halted = 1'b0;
    repeat (3) @(negedge clk);
    if (m_phase == 1) m_phase = 2;
  endtask
  initial begin
    int t, n, r;
    bus.up_btn = 1'b0;
    bus.down_btn = 1'b0;
    bus.select_btn = 1'b0;
    bus.cpu_halted = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset");
    rst = 1'b1;
    @(negedge clk);
    bus.up_btn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      chk("latency", 32'(bus.sel_index), (i >= D + 3) ? 32'd1 : 32'd0);
    end
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.up_btn = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    m_idx = 1;
    chk_all("up1");
    press(1, 0, 0); chk_all("up2");
    press(1, 0, 0); chk_all("up3");
    press(1, 0, 0); chk_all("up_wrap");
    press(0, 1, 0); chk_all("down_wrap");
    @(negedge clk);
    bus.up_btn = 1'b1;
    repeat (2) @(negedge clk);
    bus.up_btn = 1'b0;
    repeat (20) @(negedge clk);
    chk_all("glitch");
    halt_pulse(); chk_all("halt_in_menu");
    press(1, 1, 0); chk_all("up_down_same");
    press(1, 0, 1); chk_all("sel_up_same");
    halt_pulse(); chk_all("halt_run");
    halt_pulse(); chk_all("halt_in_done");
    press(0, 0, 1); chk_all("done_exit");
    @(negedge clk);
    bus.select_btn = 1'b1;
    t = 0;
    while (!bus.selection_done && t < 40) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    while (bus.selection_done && !bus.cpu_rst_n && !bus.mode && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("arm_len", 32'(n), 32'd4);
    chk("arm_exit_mode", 32'(bus.mode), 32'd1);
    chk("arm_exit_cpurstn", 32'(bus.cpu_rst_n), 32'd1);
    bus.select_btn = 1'b0;
    repeat (20) @(negedge clk);
    m_phase = 1;
    chk_all("run");
    @(negedge clk);
    bus.select_btn = 1'b1;
    repeat (D + 3) @(posedge clk);
    #1 bus.cpu_halted = 1'b1;
    @(posedge clk);
    #1 bus.cpu_halted = 1'b0;
    m_phase = 0;
    chk_all("abort_vs_halt");
    @(negedge clk);
    bus.select_btn = 1'b0;
    repeat (20) @(negedge clk);
    chk_all("abort_settled");
    press(0, 0, 1); chk_all("run2");
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    m_phase = 0;
    m_idx = 0;
    chk_all("async_rst");
    bus.up_btn = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.up_btn = 1'b0;
    repeat (20) @(negedge clk);
    m_idx = 1;
    chk_all("held_over_rst");
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) press(1, 0, 0);
      else if (r < 6) press(0, 1, 0);
      else if (r == 6) press(1, 1, 0);
      else if (r == 7) press(0, 0, 1);
      else if (r == 8) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      else halt_pulse();
      chk_all("random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
